// File: rtl/ir_sensor_intf_pkg.sv
// ir_pkg: shared types and constants for the IR sensor interface.
//   ir_state_t   - conversion-round FSM states
//   CMD_CHNL_LSB - bit position of the 3-bit channel field in the SPI command
//   ir_cmd()     - builds a command word {2'b00, chnl, 11'h000}
//   DTRM_MAX/MIN - saturation bounds of the IR derivative output
package ir_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD_L1,
        WAIT_L1,
        CMD_L2,
        WAIT_L2,
        CMD_R1,
        WAIT_R1,
        CMD_R2,
        WAIT_R2,
        UPDATE
    } ir_state_t;

    localparam int CMD_CHNL_LSB = 11;

    localparam int DTRM_MAX = 255;
    localparam int DTRM_MIN = -256;

    function automatic logic [15:0] ir_cmd(input logic [2:0] chnl);
        logic [15:0] c;
        c = '0;
        c[CMD_CHNL_LSB +: 3] = chnl;
        return c;
    endfunction

endpackage

// File: rtl/ir_sensor_intf_opn_hyst.sv
// ir_opn_hyst: per-side "open" detector with hysteresis.
//   clk, rst  - clock, synchronous active-high reset (flag resets to open)
//   upd       - load the evaluated flag this cycle
//   sample    - new 12-bit reading
//   opn       - registered open flag
//   opn_nxt   - flag value that upd would load (used by the derivative gating)
module ir_opn_hyst #(
    parameter logic [11:0] THRES = 12'h600,
    parameter logic [11:0] HYST  = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd,
    input  logic [11:0] sample,
    output logic        opn,
    output logic        opn_nxt
);

    localparam logic [11:0] SET_LVL = THRES - HYST;
    localparam logic [11:0] CLR_LVL = THRES + HYST;

    always_comb begin
        opn_nxt = opn;
        if (sample < SET_LVL) begin
            opn_nxt = 1'b1;
        end else if (sample > CLR_LVL) begin
            opn_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opn <= 1'b1;
        end else if (upd) begin
            opn <= opn_nxt;
        end
    end

endmodule

// File: rtl/ir_sensor_intf.sv
// ir_sensor_intf: periodically runs a two-channel A2D round over SPI and
// publishes left/right IR readings, open flags and a saturated derivative.
//   clk, rst  - clock, synchronous active-high reset
//   en        - enables the round timer
//   wrt, cmd  - SPI transaction start pulse and command word
//   done      - SPI transaction complete pulse, rd_data valid with it
//   lft_IR, rght_IR   - latest readings
//   lft_opn, rght_opn - open (no wall) flags
//   IR_Dtrm   - signed derivative of (left - right), saturated to 9 bits
//   IR_vld    - one-cycle pulse, outputs hold the new round's values
module ir_sensor_intf
    import ir_pkg::*;
#(
    parameter int          SAMPLE_PERIOD = 4096,
    parameter logic [2:0]  CH_LFT        = 3'd0,
    parameter logic [2:0]  CH_RGHT       = 3'd1,
    parameter logic [11:0] OPN_THRES     = 12'h600,
    parameter logic [11:0] OPN_HYST      = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_IR,
    output logic [11:0] rght_IR,
    output logic        lft_opn,
    output logic        rght_opn,
    output logic [8:0]  IR_Dtrm,
    output logic        IR_vld
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [TW-1:0]        T_LAST  = TW'(SAMPLE_PERIOD - 1);
    localparam logic signed [13:0]   RAW_MAX = 14'(DTRM_MAX);
    localparam logic signed [13:0]   RAW_MIN = 14'(DTRM_MIN);
    localparam logic signed [8:0]    DT_MAX  = 9'(DTRM_MAX);
    localparam logic signed [8:0]    DT_MIN  = 9'(DTRM_MIN);

    logic [TW-1:0] timer;
    logic          trigger;
    ir_state_t     state, state_nxt;

    logic [11:0]        lft_smp;
    logic [11:0]        rght_new;
    logic               upd;
    logic               lft_opn_nxt, rght_opn_nxt;
    logic signed [12:0] diff, prev_diff;
    logic signed [13:0] raw;
    logic               prev_valid;
    logic [8:0]         dtrm_nxt;
    logic               unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

    // Round timer: held at 0 while disabled; the wrap cycle is the trigger.
    assign trigger = en && (timer == T_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en || trigger) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        cmd       = '0;
        IR_vld    = 1'b0;
        case (state)
            IDLE:    if (trigger) state_nxt = CMD_L1;
            CMD_L1:  begin wrt = 1'b1; cmd = ir_cmd(CH_LFT);  state_nxt = WAIT_L1; end
            WAIT_L1: if (done) state_nxt = CMD_L2;
            CMD_L2:  begin wrt = 1'b1; cmd = ir_cmd(CH_LFT);  state_nxt = WAIT_L2; end
            WAIT_L2: if (done) state_nxt = CMD_R1;
            CMD_R1:  begin wrt = 1'b1; cmd = ir_cmd(CH_RGHT); state_nxt = WAIT_R1; end
            WAIT_R1: if (done) state_nxt = CMD_R2;
            CMD_R2:  begin wrt = 1'b1; cmd = ir_cmd(CH_RGHT); state_nxt = WAIT_R2; end
            WAIT_R2: if (done) state_nxt = UPDATE;
            UPDATE:  begin IR_vld = 1'b1; state_nxt = IDLE; end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lft_smp <= '0;
        end else if (state == WAIT_L2 && done) begin
            lft_smp <= rd_data[11:0];
        end
    end

    // Output registers load on the final done (the edge entering UPDATE), so
    // every output already carries the new round while IR_vld is high.
    assign upd      = (state == WAIT_R2) && done;
    assign rght_new = rd_data[11:0];

    ir_opn_hyst #(.THRES(OPN_THRES), .HYST(OPN_HYST)) u_lft_hyst (
        .clk     (clk),
        .rst     (rst),
        .upd     (upd),
        .sample  (lft_smp),
        .opn     (lft_opn),
        .opn_nxt (lft_opn_nxt)
    );

    ir_opn_hyst #(.THRES(OPN_THRES), .HYST(OPN_HYST)) u_rght_hyst (
        .clk     (clk),
        .rst     (rst),
        .upd     (upd),
        .sample  (rght_new),
        .opn     (rght_opn),
        .opn_nxt (rght_opn_nxt)
    );

    assign diff = {1'b0, lft_smp} - {1'b0, rght_new};
    assign raw  = {diff[12], diff} - {prev_diff[12], prev_diff};

    always_comb begin
        dtrm_nxt = '0;
        if (!prev_valid || lft_opn_nxt || rght_opn_nxt) begin
            dtrm_nxt = '0;
        end else if (raw > RAW_MAX) begin
            dtrm_nxt = DT_MAX;
        end else if (raw < RAW_MIN) begin
            dtrm_nxt = DT_MIN;
        end else begin
            dtrm_nxt = raw[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lft_IR     <= '0;
            rght_IR    <= '0;
            IR_Dtrm    <= '0;
            prev_diff  <= '0;
            prev_valid <= 1'b0;
        end else if (upd) begin
            lft_IR     <= lft_smp;
            rght_IR    <= rght_new;
            IR_Dtrm    <= dtrm_nxt;
            prev_diff  <= diff;
            prev_valid <= 1'b1;
        end
    end

endmodule
